// File: rtl/rf_scoreboard_pkg.sv
// Shared constants for the register-file scoreboard: register index width,
// register count, pending-counter width and inflight accounting limits.
package rf_scoreboard_pkg;

    localparam int REG_IDX_W  = 5;
    localparam int SB_NREG    = 32;
    localparam int SB_CNT_W   = 2;
    localparam int INFLIGHT_W = 4;

    localparam logic [REG_IDX_W-1:0]  REG_ZERO     = 5'd0;
    localparam logic [INFLIGHT_W-1:0] INFLIGHT_MAX = 4'd15;

endpackage

// File: rtl/rf_scoreboard_chk.sv
// Simulation checks on the scoreboard's protocol and output consistency.
module rf_scoreboard_chk
    import rf_scoreboard_pkg::*;
#(
    parameter int NREG = SB_NREG
) (
    input logic                  clk,
    input logic                  rst,
    input logic                  retire_underflow,
    input logic                  issue_overflow,
    input logic [NREG-1:0]       busy_vec,
    input logic [INFLIGHT_W-1:0] inflight,
    input logic                  idle
);

    a_no_underflow: assert property (@(posedge clk) disable iff (rst) !retire_underflow)
        else $error("retire on a register with no pending writer");

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !issue_overflow)
        else $error("issue on a saturated pending counter");

    a_r0_idle: assert property (@(posedge clk) disable iff (rst) !busy_vec[0])
        else $error("r0 reported busy");

    a_idle_consistent: assert property (@(posedge clk) disable iff (rst)
        idle == (inflight == {INFLIGHT_W{1'b0}}))
        else $error("idle disagrees with inflight");

endmodule

// File: rtl/rf_scoreboard_counter.sv
// sb_counter: one per-register pending-writer counter. Saturates at both
// ends so a protocol slip can never wrap the count; clr wins over inc/dec.
module sb_counter
    import rf_scoreboard_pkg::*;
#(
    parameter int CNT_W = SB_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             is_max,
    output logic             is_zero
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;

    // Next count: clear, saturating increment, floored decrement, or hold.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (clr) begin
            cnt_nxt_s = CNT_ZERO;
        end else if (inc && !dec) begin
            if (cnt_r != CNT_MAX) begin
                cnt_nxt_s = cnt_r + CNT_ONE;
            end else begin
                cnt_nxt_s = cnt_r;
            end
        end else if (dec && !inc) begin
            if (cnt_r != CNT_ZERO) begin
                cnt_nxt_s = cnt_r - CNT_ONE;
            end else begin
                cnt_nxt_s = cnt_r;
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= CNT_ZERO;
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    assign cnt     = cnt_r;
    assign is_max  = (cnt_r == CNT_MAX);
    assign is_zero = (cnt_r == CNT_ZERO);

endmodule

// File: rtl/rf_scoreboard.sv
// Register-file scoreboard: counts in-flight writers per architectural
// register between ID issue and WB retire and produces the ID-stage stall
// for RAW hazards and per-register counter saturation.
module rf_scoreboard
    import rf_scoreboard_pkg::*;
#(
    parameter int   NREG          = SB_NREG,
    parameter int   CNT_W         = SB_CNT_W,
    parameter logic RETIRE_BYPASS = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [REG_IDX_W-1:0]  id_rj,
    input  logic                  id_rj_used,
    input  logic [REG_IDX_W-1:0]  id_rk,
    input  logic                  id_rk_used,
    input  logic [REG_IDX_W-1:0]  id_rd,
    input  logic                  id_rd_we,
    input  logic                  id_fire,
    input  logic                  wb_fire,
    input  logic [REG_IDX_W-1:0]  wb_rd,
    input  logic                  wb_we,
    output logic                  id_stall,
    output logic [NREG-1:0]       busy_vec,
    output logic [INFLIGHT_W-1:0] inflight,
    output logic                  idle
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

    logic                  issue_s;
    logic                  retire_s;
    logic [NREG-1:0]       inc_s;
    logic [NREG-1:0]       dec_s;
    logic [NREG-1:0]       zero_vec_s;
    logic [NREG-1:0]       max_vec_s;
    logic [CNT_W-1:0]      cnt_s [NREG];
    logic                  rj_busy_s;
    logic                  rk_busy_s;
    logic                  rd_sat_s;
    logic                  underflow_s;
    logic                  overflow_s;
    logic [INFLIGHT_W-1:0] inflight_r;
    logic [INFLIGHT_W-1:0] inflight_nxt_s;
    logic                  idle_r;

    // Writes to r0 are never tracked; flush discards same-cycle traffic.
    assign issue_s  = id_fire & id_rd_we & (id_rd != REG_ZERO) & ~flush;
    assign retire_s = wb_fire & wb_we & (wb_rd != REG_ZERO) & ~flush;

    // Decode issue/retire into per-register increment/decrement strobes.
    always_comb begin
        inc_s = {NREG{1'b0}};
        dec_s = {NREG{1'b0}};
        for (int i = 1; i < NREG; i++) begin
            inc_s[i] = issue_s  && (id_rd == REG_IDX_W'(i));
            dec_s[i] = retire_s && (wb_rd == REG_IDX_W'(i));
        end
    end

    genvar g;
    generate
        for (g = 1; g < NREG; g++) begin : g_cnt
            sb_counter #(.CNT_W(CNT_W)) u_cnt (
                .clk     (clk),
                .rst     (rst),
                .clr     (flush),
                .inc     (inc_s[g]),
                .dec     (dec_s[g]),
                .cnt     (cnt_s[g]),
                .is_max  (max_vec_s[g]),
                .is_zero (zero_vec_s[g])
            );
        end
    endgenerate

    assign cnt_s[0]      = {CNT_W{1'b0}};
    assign max_vec_s[0]  = 1'b0;
    assign zero_vec_s[0] = 1'b1;

    // Hazard query: a source is busy while writers are pending, unless the
    // last pending writer retires this very cycle and bypass is enabled.
    // A full counter on rd stalls unless a retire on rd frees a slot now.
    always_comb begin
        rj_busy_s = (id_rj != REG_ZERO) && !zero_vec_s[id_rj] &&
                    !(RETIRE_BYPASS && retire_s && (wb_rd == id_rj) && (cnt_s[id_rj] == CNT_ONE));
        rk_busy_s = (id_rk != REG_ZERO) && !zero_vec_s[id_rk] &&
                    !(RETIRE_BYPASS && retire_s && (wb_rd == id_rk) && (cnt_s[id_rk] == CNT_ONE));
        rd_sat_s  = id_rd_we && (id_rd != REG_ZERO) && max_vec_s[id_rd] &&
                    !(retire_s && (wb_rd == id_rd));
        id_stall  = id_valid && ((id_rj_used && rj_busy_s) ||
                                 (id_rk_used && rk_busy_s) || rd_sat_s);
    end

    // Next inflight total: same +1/-1/0 rule as a counter, clamped to 0..15.
    always_comb begin
        inflight_nxt_s = inflight_r;
        if (flush) begin
            inflight_nxt_s = {INFLIGHT_W{1'b0}};
        end else if (issue_s && !retire_s) begin
            if (inflight_r != INFLIGHT_MAX) begin
                inflight_nxt_s = inflight_r + 4'd1;
            end else begin
                inflight_nxt_s = inflight_r;
            end
        end else if (retire_s && !issue_s) begin
            if (inflight_r != 4'd0) begin
                inflight_nxt_s = inflight_r - 4'd1;
            end else begin
                inflight_nxt_s = inflight_r;
            end
        end else begin
            inflight_nxt_s = inflight_r;
        end
    end

    // Inflight and idle registers; idle is registered alongside the total.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_r <= {INFLIGHT_W{1'b0}};
            idle_r     <= 1'b1;
        end else begin
            inflight_r <= inflight_nxt_s;
            idle_r     <= (inflight_nxt_s == 4'd0);
        end
    end

    assign inflight = inflight_r;
    assign idle     = idle_r;
    assign busy_vec = ~zero_vec_s;

    assign underflow_s = |(dec_s & zero_vec_s);
    assign overflow_s  = |(inc_s & ~dec_s & max_vec_s);

    rf_scoreboard_chk #(.NREG(NREG)) u_chk (
        .clk              (clk),
        .rst              (rst),
        .retire_underflow (underflow_s),
        .issue_overflow   (overflow_s),
        .busy_vec         (busy_vec),
        .inflight         (inflight),
        .idle             (idle)
    );

endmodule

// File: tb/tb_rf_scoreboard.sv
// Bench for rf_scoreboard: directed scenarios with literal expectations,
// then randomized in-order issue/retire traffic against a counting model.
module tb_rf_scoreboard;

    localparam int NREG = 32;
    localparam int MAXC = 3;
    localparam int IMAX = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rj = 5'd0;
    logic        id_rj_used = 1'b0;
    logic [4:0]  id_rk = 5'd0;
    logic        id_rk_used = 1'b0;
    logic [4:0]  id_rd = 5'd0;
    logic        id_rd_we = 1'b0;
    logic        id_fire = 1'b0;
    logic        wb_fire = 1'b0;
    logic [4:0]  wb_rd = 5'd0;
    logic        wb_we = 1'b0;
    logic        id_stall;
    logic [31:0] busy_vec;
    logic [3:0]  inflight;
    logic        idle;

    rf_scoreboard dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .id_valid   (id_valid),
        .id_rj      (id_rj),
        .id_rj_used (id_rj_used),
        .id_rk      (id_rk),
        .id_rk_used (id_rk_used),
        .id_rd      (id_rd),
        .id_rd_we   (id_rd_we),
        .id_fire    (id_fire),
        .wb_fire    (wb_fire),
        .wb_rd      (wb_rd),
        .wb_we      (wb_we),
        .id_stall   (id_stall),
        .busy_vec   (busy_vec),
        .inflight   (inflight),
        .idle       (idle)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int m_cnt [NREG];
    int m_infl = 0;
    bit chk_en = 1'b0;
    int pend_q [$];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_issue();
        return id_fire && id_rd_we && (id_rd != 5'd0) && !flush;
    endfunction

    function automatic bit m_retire();
        return wb_fire && wb_we && (wb_rd != 5'd0) && !flush;
    endfunction

    function automatic bit m_busy(input logic [4:0] r);
        if (r == 5'd0 || m_cnt[r] == 0) return 1'b0;
        if (m_retire() && wb_rd == r && m_cnt[r] == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_stall();
        bit sat;
        sat = id_rd_we && (id_rd != 5'd0) && (m_cnt[id_rd] == MAXC) &&
              !(m_retire() && wb_rd == id_rd);
        return id_valid && ((id_rj_used && m_busy(id_rj)) ||
                            (id_rk_used && m_busy(id_rk)) || sat);
    endfunction

    // Compare DUT against the model for the current cycle, then advance it.
    task automatic compare_and_update();
        logic [31:0] exp_bv;
        int v;
        if (chk_en) begin
            exp_bv = 32'd0;
            for (int i = 1; i < NREG; i++) exp_bv[i] = (m_cnt[i] != 0);
            chk("id_stall", int'(id_stall), int'(m_stall()));
            chk("busy_vec", int'(busy_vec), int'(exp_bv));
            chk("inflight", int'(inflight), m_infl);
            chk("idle", int'(idle), int'(m_infl == 0));
        end
        if (rst || flush) begin
            for (int i = 0; i < NREG; i++) m_cnt[i] = 0;
            m_infl = 0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                v = m_cnt[i] + int'(m_issue() && id_rd == 5'(i)) - int'(m_retire() && wb_rd == 5'(i));
                m_cnt[i] = (v < 0) ? 0 : ((v > MAXC) ? MAXC : v);
            end
            v = m_infl + int'(m_issue()) - int'(m_retire());
            m_infl = (v < 0) ? 0 : ((v > IMAX) ? IMAX : v);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_and_update();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [4:0] rj, input logic ju,
                       input logic [4:0] rk, input logic ku,
                       input logic [4:0] rd, input logic we, input logic f,
                       input logic wf, input logic [4:0] wr, input logic wwe,
                       input logic fl);
        id_valid = v;  id_rj = rj; id_rj_used = ju; id_rk = rk; id_rk_used = ku;
        id_rd = rd;    id_rd_we = we; id_fire = f;
        wb_fire = wf;  wb_rd = wr; wb_we = wwe; flush = fl;
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset state, query r5 with no traffic.
        drv(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("reset_stall", int'(id_stall), 0);
        chk("reset_idle", int'(idle), 1);
        chk("reset_busy", int'(busy_vec), 0);
        chk("reset_inflight", int'(inflight), 0);
        tick();

        // RAW on r5, retired three cycles after issue with bypass.
        drv(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0); tick();
        drv(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("raw_stall", int'(id_stall), 1);
        chk("raw_busy5", int'(busy_vec[5]), 1);
        chk("raw_inflight", int'(inflight), 1);
        tick();
        tick();
        drv(1, 5, 1, 0, 0, 0, 0, 0, 1, 5, 1, 0); #1;
        chk("bypass_stall", int'(id_stall), 0);
        tick();
        drv(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("after_retire_stall", int'(id_stall), 0);
        chk("after_retire_busy5", int'(busy_vec[5]), 0);
        chk("after_retire_idle", int'(idle), 1);
        tick();

        // Saturate r7, then release with a same-cycle retire.
        for (int k = 0; k < 3; k++) begin
            drv(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0); tick();
        end
        drv(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0); #1;
        chk("sat_stall", int'(id_stall), 1);
        chk("sat_inflight", int'(inflight), 3);
        tick();
        drv(1, 0, 0, 0, 0, 7, 1, 1, 1, 7, 1, 0); #1;
        chk("sat_release", int'(id_stall), 0);
        tick();
        drv(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0); #1;
        chk("sat_hold_stall", int'(id_stall), 1);
        chk("sat_hold_inflight", int'(inflight), 3);
        tick();

        // Same-cycle issue and retire of r9 with one pending writer.
        drv(1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 0); tick();
        drv(1, 9, 1, 0, 0, 9, 1, 1, 1, 9, 1, 0); #1;
        chk("r9_bypass_stall", int'(id_stall), 0);
        chk("r9_inflight_pre", int'(inflight), 4);
        tick();
        drv(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("r9_still_busy", int'(id_stall), 1);
        chk("r9_inflight", int'(inflight), 4);
        tick();

        // r0 is never tracked.
        drv(1, 0, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0); #1;
        chk("r0_stall", int'(id_stall), 0);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("r0_inflight", int'(inflight), 4);
        tick();

        // Pending r3, r4, r5, then flush with concurrent issue and retire.
        drv(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0); tick();
        drv(1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0, 0); tick();
        drv(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0); tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("preflush_inflight", int'(inflight), 7);
        chk("preflush_busy", int'(busy_vec), 32'h0000_02B8);
        drv(1, 0, 0, 0, 0, 6, 1, 1, 1, 3, 1, 1); tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("flush_inflight", int'(inflight), 0);
        chk("flush_idle", int'(idle), 1);
        chk("flush_busy", int'(busy_vec), 0);
        tick();

        // Reset mid-operation overrides a concurrent issue.
        drv(1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0, 0); tick();
        drv(1, 0, 0, 0, 0, 8, 1, 1, 1, 2, 1, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drv(1, 2, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("rst_mid_stall", int'(id_stall), 0);
        chk("rst_mid_inflight", int'(inflight), 0);
        chk("rst_mid_busy", int'(busy_vec), 0);
        tick();

        // Randomized in-order traffic; retires follow issue order.
        pend_q.delete();
        for (int c = 0; c < 3000; c++) begin
            rst   = ($urandom_range(0, 299) == 0);
            flush = ($urandom_range(0, 63) == 0);
            id_valid   = ($urandom_range(0, 3) != 0);
            id_rj      = 5'($urandom_range(0, 7));
            id_rj_used = 1'($urandom_range(0, 1));
            id_rk      = 5'($urandom_range(0, 7));
            id_rk_used = 1'($urandom_range(0, 1));
            id_rd      = 5'($urandom_range(0, 7));
            id_rd_we   = ($urandom_range(0, 3) != 0);
            if (pend_q.size() > 0 && $urandom_range(0, 2) == 0) begin
                wb_fire = 1'b1;
                wb_we   = 1'b1;
                wb_rd   = 5'(pend_q[0]);
            end else begin
                wb_fire = 1'($urandom_range(0, 1));
                wb_we   = 1'b0;
                wb_rd   = 5'($urandom_range(0, 31));
            end
            id_fire = id_valid && ($urandom_range(0, 3) != 0) && !m_stall();
            if (rst || flush) begin
                pend_q.delete();
            end else begin
                if (m_retire()) void'(pend_q.pop_front());
                if (m_issue()) pend_q.push_back(int'(id_rd));
            end
            tick();
        end

        rst = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rf_scoreboard.md
Name: rf_scoreboard

Overview:
Register-file scoreboard and issue controller for the 5-stage in-order pipeline.
- Counts in-flight writers per architectural register between ID issue and WB retire.
- Drives the ID-stage stall (ID readygo = ~id_stall) for RAW hazards on rj/rk and for per-register counter saturation.
- Sits beside the ID stage; the retire side is fed by the WB stage's register-file write outputs.

Parameters:
NREG, 32, number of architectural registers; r0 is never tracked.
CNT_W, 2, width of each per-register pending counter; max count = 2^CNT_W-1.
RETIRE_BYPASS, 1, 1 = a same-cycle retire clears busy for a query seeing count==1.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
flush  in  1  pipeline flush (exception/ertn); clears all pending state
id_valid  in  1  ID stage holds a valid instruction
id_rj  in  5  source register 1
id_rj_used  in  1  instruction reads rj
id_rk  in  5  source register 2
id_rk_used  in  1  instruction reads rk
id_rd  in  5  destination register
id_rd_we  in  1  instruction writes rd
id_fire  in  1  ID->EX handshake (ID validout & EX allowin)
wb_fire  in  1  WB retires an instruction this cycle
wb_rd  in  5  retiring destination register
wb_we  in  1  retiring instruction writes rd
id_stall  out  1  hold ID (combinational)
busy_vec  out  NREG  bit i = register i has pending writers (registered view)
inflight  out  4  total pending writes, saturating at 15
idle  out  1  inflight == 0

Behaviour:
- State: cnt[i] (CNT_W bits) for i = 1..NREG-1; cnt[0] is constant 0.
- Reset: all cnt = 0, inflight = 0, idle = 1, busy_vec = 0, id_stall = 0 (no sources in use at reset).
- issue = id_fire & id_rd_we & (id_rd != 0) & ~flush.
- retire = wb_fire & wb_we & (wb_rd != 0) & ~flush.
- Per-register update each cycle:
  - issue only: +1.
  - retire only: -1.
  - Both on the same register: unchanged.
  - Different registers: each updated independently.
- inflight tracks the sum of cnt; updated with the same +1/-1/0 rule, saturating at 15.
- Flush takes priority. Next cycle all cnt = 0 and inflight = 0; the same-cycle issue and retire are discarded.
- busy(r):
  - (cnt[r] != 0), except with RETIRE_BYPASS=1 and retire on r with cnt[r]==1, where busy(r) = 0.
  - r0 is never busy.
- id_stall = id_valid & ((id_rj_used & busy(id_rj)) | (id_rk_used & busy(id_rk)) | (id_rd_we & id_rd!=0 & cnt[id_rd]==max & ~(retire & wb_rd==id_rd))).
- id_stall does not depend on id_fire, so there is no combinational loop.
- Retire on a register with cnt==0 is a protocol error. The counter stays at 0 (no underflow) and a simulation-only assertion fires.
- Issue on a saturated counter cannot occur while id_stall is honoured. If it does occur anyway, the counter holds at max and an assertion fires.
- busy_vec is the registered cnt!=0 vector. It omits the bypass and is intended for debug and trace only.
- Latency: issue is visible to a query in the cycle after id_fire. With RETIRE_BYPASS=1, retire is visible in the same cycle; otherwise in the next cycle.
- Reset asserted mid-operation overrides flush, issue and retire; all state is cleared next cycle.

Decomposition:
- Shared package: register index width (5), NREG, CNT_W, and the r0 constant.
- Sub-module sb_counter: one per-register saturating up/down counter with inputs inc, dec, clr and outputs cnt, is_max, is_zero. It is instantiated NREG-1 times via generate.
- Hazard logic and inflight accounting live in the top level.

Test Plan:
- Reset, then query rj=5 (used) with no traffic -> id_stall=0, idle=1, busy_vec=0.
- Issue rd=5 (id_fire=1). Next cycle, ID reads rj=5 -> id_stall=1. WB retires rd=5 three cycles later: with RETIRE_BYPASS=1, stall drops that same cycle; cnt[5]=0 the following cycle.
- Issue rd=7 three times back-to-back with no retire -> cnt[7]=3. A fourth writer to r7 -> id_stall=1. In a cycle with wb retire r7, the stall releases and cnt stays 3.
- Same-cycle issue rd=9 and retire rd=9 with cnt[9]=1 -> cnt[9] stays 1, inflight unchanged.
- Issue rd=0 and read rj=0 -> no count change, id_stall=0.
- Pending r3, r4, r5, then flush with a concurrent issue rd=6 and retire rd=3 -> next cycle all cnt=0, inflight=0, idle=1.
